// File: rtl/demux2x5_buf_if.sv
// demux2x5_buf_if -- bundle of the producer and consumer signals of demux2x5_buf.
//
// Handshake rule (both the input side and each output channel): a word moves
// on a rising clock edge exactly when its valid and ready are both 1 in the
// cycle before that edge. in_ready depends only on in_sel and the selected
// channel's fill level, never on in_valid or out0/out1_ready.
//
// Signals:
//   in_valid, in_sel, in_data[4:0] : producer offers a word for channel in_sel
//   in_ready                        : block accepts the offered word
//   outX_valid, outX_data[4:0]      : channel X head word (data 0 when empty)
//   outX_ready                      : consumer takes channel X head
//   outX_cnt[CNT_W-1:0]             : words delivered on channel X (wrapping)
// Modports: master = producer/consumer side, slave = the demux block.
interface demux2x5_buf_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic             in_sel;
    logic [4:0]       in_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [4:0]       out0_data;
    logic [CNT_W-1:0] out0_cnt;
    logic             out1_valid;
    logic             out1_ready;
    logic [4:0]       out1_data;
    logic [CNT_W-1:0] out1_cnt;

    modport master (
        output in_valid, in_sel, in_data, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_data, out0_cnt,
               out1_valid, out1_data, out1_cnt
    );

    modport slave (
        input  in_valid, in_sel, in_data, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_data, out0_cnt,
               out1_valid, out1_data, out1_cnt
    );
endinterface

// File: rtl/demux2x5_buf.sv
// demux2x5_buf -- routes 5-bit words to one of two channels, each buffered by
// an independent 2-entry FIFO with a per-channel delivered-word counter.
//
// Ports:
//   clk  : rising-edge clock
//   clrn : asynchronous active-low clear of all state
//   bus  : demux2x5_buf_if.slave (input handshake, two output channels)
module demux2x5_buf #(
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          clrn,
    demux2x5_buf_if.slave bus
);

    // Per-channel storage: entry 0 is always the head, entry 1 the second word.
    logic [4:0]       mem [2][2];
    logic [1:0]       occ [2];
    logic [CNT_W-1:0] cnt [2];
    logic [1:0]       push;
    logic [1:0]       pop;
    logic [1:0]       out_ready;

    assign out_ready = {bus.out1_ready, bus.out0_ready};

    // No pass-through: a full channel refuses even if its consumer is ready.
    assign bus.in_ready = (occ[bus.in_sel] != 2'd2);

    always_comb begin
        push    = 2'b00;
        pop     = 2'b00;
        push[0] = bus.in_valid && bus.in_ready && !bus.in_sel;
        push[1] = bus.in_valid && bus.in_ready &&  bus.in_sel;
        pop[0]  = (occ[0] != 2'd0) && out_ready[0];
        pop[1]  = (occ[1] != 2'd0) && out_ready[1];
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int c = 0; c < 2; c++) begin
                occ[c]    <= '0;
                cnt[c]    <= '0;
                mem[c][0] <= '0;
                mem[c][1] <= '0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (pop[c]) begin
                    cnt[c] <= cnt[c] + CNT_W'(1);
                end
                case ({push[c], pop[c]})
                    2'b10: begin
                        // occ is 0 or 1 here, so its low bit is the free slot
                        mem[c][occ[c][0]] <= bus.in_data;
                        occ[c]            <= occ[c] + 2'd1;
                    end
                    2'b01: begin
                        mem[c][0] <= mem[c][1];
                        occ[c]    <= occ[c] - 2'd1;
                    end
                    2'b11: begin
                        // Only reachable at occupancy 1: new word replaces the head
                        mem[c][0] <= bus.in_data;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.out0_valid = (occ[0] != 2'd0);
    assign bus.out1_valid = (occ[1] != 2'd0);
    assign bus.out0_data  = (occ[0] != 2'd0) ? mem[0][0] : 5'b00000;
    assign bus.out1_data  = (occ[1] != 2'd0) ? mem[1][0] : 5'b00000;
    assign bus.out0_cnt   = cnt[0];
    assign bus.out1_cnt   = cnt[1];

endmodule

// File: tb/tb_demux2x5_buf.sv
// tb_demux2x5_buf -- directed plus randomized bench for demux2x5_buf, checked
// against a queue-based reference of the two channels.
module tb_demux2x5_buf;
    localparam int CNT_W = 8;
    localparam int CMOD  = 1 << CNT_W;

    logic clk = 1'b0;
    logic clrn;

    always #5 clk = ~clk;

    demux2x5_buf_if #(.CNT_W(CNT_W)) bus ();

    demux2x5_buf #(.CNT_W(CNT_W)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    // Reference: one queue per channel plus delivered counts.
    logic [4:0] q0 [$];
    logic [4:0] q1 [$];
    int cnt0;
    int cnt1;

    int vectors = 0;
    int errs    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic sel, input logic [4:0] d,
                         input logic r0, input logic r1);
        bus.in_valid   = v;
        bus.in_sel     = sel;
        bus.in_data    = d;
        bus.out0_ready = r0;
        bus.out1_ready = r1;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ":out0_valid"}, bus.out0_valid, q0.size() > 0);
        chk({tag, ":out1_valid"}, bus.out1_valid, q1.size() > 0);
        chk({tag, ":out0_data"},  bus.out0_data,  q0.size() > 0 ? q0[0] : 5'b00000);
        chk({tag, ":out1_data"},  bus.out1_data,  q1.size() > 0 ? q1[0] : 5'b00000);
        chk({tag, ":out0_cnt"},   bus.out0_cnt,   cnt0);
        chk({tag, ":out1_cnt"},   bus.out1_cnt,   cnt1);
    endtask

    task automatic model_clear();
        q0.delete();
        q1.delete();
        cnt0 = 0;
        cnt1 = 0;
    endtask

    // One clock: called in the low phase with inputs already driven; ends at
    // the next falling edge with outputs checked against the reference.
    task automatic cycle(input string tag);
        logic rdy, push0, push1, pop0, pop1;
        logic [4:0] d;
        #1;
        rdy = bus.in_sel ? (q1.size() < 2) : (q0.size() < 2);
        chk({tag, ":in_ready"}, bus.in_ready, rdy);
        push0 = bus.in_valid && rdy && !bus.in_sel;
        push1 = bus.in_valid && rdy &&  bus.in_sel;
        pop0  = (q0.size() > 0) && bus.out0_ready;
        pop1  = (q1.size() > 0) && bus.out1_ready;
        d     = bus.in_data;
        @(posedge clk);
        if (pop0) begin void'(q0.pop_front()); cnt0 = (cnt0 + 1) % CMOD; end
        if (pop1) begin void'(q1.pop_front()); cnt1 = (cnt1 + 1) % CMOD; end
        if (push0) q0.push_back(d);
        if (push1) q1.push_back(d);
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        model_clear();
        clrn = 1'b0;
        // Offer a word while held in reset: it must not be taken.
        drive(1'b1, 1'b0, 5'h07, 1'b1, 1'b1);
        #3;
        check_outputs("in_reset");
        chk("in_reset:in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check_outputs("in_reset_edge");
        drive(1'b0, 1'b0, 5'h00, 1'b0, 1'b0);
        clrn = 1'b1;

        // Post-reset idle.
        cycle("idle");
        chk("idle:out0_cnt_zero", bus.out0_cnt, 0);

        // Single push to channel 1.
        drive(1'b1, 1'b1, 5'b11111, 1'b0, 1'b0);
        cycle("push_ch1");
        chk("push_ch1:out1_data", bus.out1_data, 5'b11111);
        chk("push_ch1:out0_valid", bus.out0_valid, 1'b0);
        // Drain channel 1.
        drive(1'b0, 1'b0, 5'h00, 1'b0, 1'b1);
        cycle("drain_ch1");

        // Fill channel 0, then probe full / other-channel readiness.
        drive(1'b1, 1'b0, 5'b10101, 1'b0, 1'b0);
        cycle("fill0_a");
        drive(1'b1, 1'b0, 5'b01010, 1'b0, 1'b0);
        cycle("fill0_b");
        drive(1'b1, 1'b0, 5'b00111, 1'b1, 1'b0);
        #1;
        chk("full0:in_ready", bus.in_ready, 1'b0);
        cycle("full0_pop");  // pop proceeds, third word refused
        chk("full0_pop:head", bus.out0_data, 5'b01010);
        drive(1'b0, 1'b1, 5'h00, 1'b0, 1'b0);
        #1;
        chk("sel1:in_ready", bus.in_ready, 1'b1);
        drive(1'b0, 1'b0, 5'h00, 1'b1, 1'b0);
        cycle("drain0");
        chk("drain0:out0_cnt", bus.out0_cnt, 2);

        // Channel 1: simultaneous push and pop at occupancy 1.
        drive(1'b1, 1'b1, 5'b00011, 1'b0, 1'b0);
        cycle("ch1_load");
        drive(1'b1, 1'b1, 5'b00100, 1'b0, 1'b1);
        cycle("ch1_pushpop");
        chk("ch1_pushpop:out1_data", bus.out1_data, 5'b00100);
        chk("ch1_pushpop:out1_cnt", bus.out1_cnt, 2);
        drive(1'b0, 1'b0, 5'h00, 1'b0, 1'b1);
        cycle("ch1_empty");
        drive(1'b0, 1'b0, 5'h00, 1'b0, 1'b1);
        cycle("ready_on_empty");

        // Counter wrap on channel 0: keep one word in flight, pop every cycle.
        drive(1'b1, 1'b0, 5'h01, 1'b0, 1'b0);
        cycle("wrap_load");
        for (int i = 0; i < CMOD - 2; i++) begin
            drive(1'b1, 1'b0, 5'($urandom_range(0, 31)), 1'b1, 1'b0);
            cycle("wrap");
        end
        chk("wrap:out0_cnt_zero", bus.out0_cnt, 0);
        drive(1'b0, 1'b0, 5'h00, 1'b1, 1'b0);
        cycle("wrap_drain");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
            cycle("rand");
        end

        // Reset mid-transfer between clock edges.
        drive(1'b0, 1'b0, 5'h00, 1'b1, 1'b1);
        cycle("pre_rst_drain");
        cycle("pre_rst_drain2");
        drive(1'b1, 1'b0, 5'h0c, 1'b0, 1'b0);
        cycle("rst_fill0a");
        drive(1'b1, 1'b0, 5'h0d, 1'b0, 1'b0);
        cycle("rst_fill0b");
        drive(1'b1, 1'b1, 5'h0e, 1'b0, 1'b0);
        cycle("rst_fill1");
        drive(1'b0, 1'b0, 5'h00, 1'b0, 1'b0);
        #2;
        clrn = 1'b0;
        #1;
        model_clear();
        check_outputs("async_rst");
        chk("async_rst:in_ready", bus.in_ready, 1'b1);
        #1;
        clrn = 1'b1;

        // First push right after reset release.
        drive(1'b1, 1'b0, 5'h13, 1'b0, 1'b0);
        cycle("post_rst_push");
        chk("post_rst_push:out0_data", bus.out0_data, 5'h13);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, expected finish before 200000");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/demux2x5_buf.md
DEMUX2X5_BUF -- requirements
Module: demux2x5_buf

Interface
Parameters:
REQ-001 CNT_W, 8: width of each per-channel transfer counter.

Ports:
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 clrn  input  1  asynchronous active-low reset; clears all state immediately on assertion.
REQ-004 in_valid  input  1  producer offers in_data this cycle.
REQ-005 in_ready  output  1  block accepts the offered word this cycle.
REQ-006 in_sel  input  1  destination of the offered word: 0 selects channel 0, 1 selects channel 1.
REQ-007 in_data  input  5  5-bit word, typically a register number.
REQ-008 out0_valid, out1_valid  output  1 each  channel has a word at its head.
REQ-009 out0_ready, out1_ready  input  1 each  consumer takes the head word this cycle.
REQ-010 out0_data, out1_data  output  5 each  head word of the channel.
REQ-011 out0_cnt, out1_cnt  output  CNT_W each  count of words delivered on the channel.

Function
REQ-012 The block SHALL hold one independent 2-entry FIFO per channel, each with an occupancy of 0..2.
REQ-013 in_ready SHALL be a combinational function of in_sel and that channel's occupancy only: in_ready = (occupancy of the selected channel < 2).
- in_ready does not depend on in_valid or on either outX_ready.
- There is no pass-through when the selected channel is full.
REQ-014 A push SHALL occur when in_valid and in_ready are both 1.
- in_data is written to the tail of the channel named by in_sel.
- The unselected channel is unaffected.
REQ-015 outX_valid SHALL be 1 exactly when channel X occupancy is at least 1.
- outX_data is the oldest entry when outX_valid is 1, and 5'b00000 when the channel is empty.
REQ-016 A pop on channel X SHALL occur when outX_valid and outX_ready are both 1.
- The head is removed at the clock edge.
- outX_cnt increments by 1 and wraps from 2^CNT_W-1 to 0.
REQ-017 Latency: a word pushed into an empty channel SHALL appear on outX_valid/outX_data in the cycle after the push edge. There is no combinational in-to-out path.
REQ-018 Simultaneous push and pop on the same channel:
- At occupancy 1: occupancy stays 1 and the pushed word becomes the new head.
- At occupancy 2: push is impossible because in_ready is 0; the pop proceeds and occupancy becomes 1.
REQ-019 Pushing one channel while popping the other SHALL update both occupancies in the same cycle.
REQ-020 outX_ready asserted while the channel is empty SHALL have no effect: no counter change, no state change.
REQ-021 Word order within each channel SHALL be strictly FIFO. No ordering is defined across channels.
REQ-022 in_sel and in_data SHALL only be sampled when in_valid is 1. When in_valid is 0 they are ignored.

Reset
REQ-023 While clrn = 0, regardless of clk, the block SHALL hold:
- both occupancies 0
- out0_valid = out1_valid = 0
- out0_data = out1_data = 5'b00000
- out0_cnt = out1_cnt = 0
- in_ready = 1
REQ-024 Reset asserted mid-transfer SHALL discard all buffered words. No pop is counted for any word still held.
REQ-025 The first push SHALL be accepted on the first rising edge after clrn deasserts.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Post-reset, no stimulus: in_ready = 1, both outX_valid = 0, both outX_data = 5'b00000, both outX_cnt = 0.
- Push in_sel = 1, in_data = 5'b11111, with out1_ready = 0: next cycle out1_valid = 1, out1_data = 5'b11111, out0_valid = 0.
- Push 5'b10101 then 5'b01010 to channel 0 with out0_ready = 0, then offer a third word to channel 0: in_ready = 0.
  Then offer in_sel = 1: in_ready = 1.
  Then drain channel 0: out0_data shows 5'b10101 then 5'b01010, and out0_cnt reaches 2.
- Channel 1 at occupancy 1 holding 5'b00011; push 5'b00100 while out1_ready = 1: occupancy stays 1, out1_data = 5'b00100, out1_cnt increments by 1.
- Pop channel 0 2^CNT_W times (256 for the default): out0_cnt wraps to 0.
- Fill channel 0 with 2 words and channel 1 with 1 word, pulse clrn low between clock edges: all outputs return to the REQ-023 values immediately without waiting for clk.
